// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: sample input side, result output side
// and the synchronous clear.
interface sum_accumulator_if #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
);
  localparam int CW = $clog2(COUNT + 1);

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_y;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [ACC_W-1:0] acc;
  logic            ovf;
  logic [CW-1:0]   cnt;

  modport master (
    output in_valid, in_y, clear, out_ready,
    input  in_ready, out_valid, acc, ovf, cnt
  );

  modport slave (
    input  in_valid, in_y, clear, out_ready,
    output in_ready, out_valid, acc, ovf, cnt
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned adder results into one sum with a sticky carry flag,
// then holds the result until the consumer takes it.
//
// state | meaning
// ACCUM | accepting samples, in_ready=1
// DONE  | batch complete, result held, out_valid=1
module sum_accumulator #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input logic              clk,
  input logic              rst_n,
  sum_accumulator_if.slave bus
);
  localparam int CW = $clog2(COUNT + 1);
  localparam int SW = ACC_W + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             restart;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [ACC_W:0]   sum_full;

  // One extra bit captures the carry out of the accumulator.
  assign sum_full = {1'b0, acc_q} + SW'(bus.in_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // clear overrides both handshakes in either state.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    restart = 1'b0;
    if (bus.clear) begin
      state_d = ACCUM;
      restart = 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            accept = 1'b1;
            if (cnt_q == CW'(COUNT - 1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = ACCUM;
            restart = 1'b1;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (restart) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= sum_full[ACC_W-1:0];
      ovf_q <= ovf_q | sum_full[ACC_W];
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.cnt       = cnt_q;
endmodule
